// File: rtl/alu_pkg.sv
// Shared types and constants for the registered ALU execute stage.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_INC  = 3'b010,
      OP_DEC  = 3'b011,
      OP_PASS = 3'b100,
      OP_NOT  = 3'b101,
      OP_OR   = 3'b110,
      OP_AND  = 3'b111
   } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one shared adder serves ADD/SUB/INC/DEC,
// logic ops bypass it. Produces the next result and status flags.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_e          op,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   logic             is_arith;
   logic             is_sub;
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;

   // Build adder operands: B or constant 1, inverted with carry-in for subtraction
   always_comb begin
      is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
      is_sub   = (op == OP_SUB) || (op == OP_DEC);
      addend   = ((op == OP_ADD) || (op == OP_SUB)) ? b : {{(WIDTH-1){1'b0}}, 1'b1};
      if (is_sub) begin
         addend = ~addend;
      end
      sum = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, is_sub};
   end

   // Select result and derive flags; carry inverts to a borrow on subtraction
   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      unique case (op)
         OP_PASS: result = a;
         OP_NOT:  result = ~a;
         OP_OR:   result = a | b;
         OP_AND:  result = a & b;
         default: result = sum[WIDTH-1:0];
      endcase
      if (is_arith) begin
         carry    = sum[WIDTH] ^ is_sub;
         overflow = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      zero     = (result == '0);
      negative = result[WIDTH-1];
   end

endmodule

// File: rtl/alu_32bit.sv
// Registered ALU execute stage: enable gating in front of an
// asynchronously reset output register, one operation per cycle.
module alu_32bit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       opcode,
   input  logic             enable,
   output logic [WIDTH-1:0] result,
   output logic             valid,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH-1:0] core_result;
   logic             core_zero;
   logic             core_negative;
   logic             core_carry;
   logic             core_overflow;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a        (A),
      .b        (B),
      .op       (alu_op_e'(opcode)),
      .result   (core_result),
      .zero     (core_zero),
      .negative (core_negative),
      .carry    (core_carry),
      .overflow (core_overflow)
   );

   // Capture the operation when enabled; otherwise register all-zero outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result   <= '0;
         valid    <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else if (enable) begin
         result   <= core_result;
         valid    <= 1'b1;
         zero     <= core_zero;
         negative <= core_negative;
         carry    <= core_carry;
         overflow <= core_overflow;
      end else begin
         result   <= '0;
         valid    <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_32bit.sv
// Table-driven self-checking bench for alu_32bit with directed reset,
// between-edge and back-to-back sequences.
module tb_alu_32bit;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  opcode;
   logic        enable;
   logic [31:0] result;
   logic        valid;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   int n_checks;
   int n_fail;

   alu_32bit #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .A        (A),
      .B        (B),
      .opcode   (opcode),
      .enable   (enable),
      .result   (result),
      .valid    (valid),
      .zero     (zero),
      .negative (negative),
      .carry    (carry),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags packed as {valid, zero, negative, carry, overflow}
   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        en;
      logic [31:0] exp_result;
      logic [4:0]  exp_flags;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end else begin
         $display("ok   %s: %08h", name, act);
      end
   endtask

   function automatic logic [31:0] flags_now();
      return {27'd0, valid, zero, negative, carry, overflow};
   endfunction

   initial begin
      vecs[0]  = '{"add_5_3",    OP_ADD,  32'd5,        32'd3, 1'b1, 32'h00000008, 5'b10000};
      vecs[1]  = '{"sub_5_3",    OP_SUB,  32'd5,        32'd3, 1'b1, 32'h00000002, 5'b10000};
      vecs[2]  = '{"inc_5",      OP_INC,  32'd5,        32'd3, 1'b1, 32'h00000006, 5'b10000};
      vecs[3]  = '{"dec_5",      OP_DEC,  32'd5,        32'd3, 1'b1, 32'h00000004, 5'b10000};
      vecs[4]  = '{"pass_5",     OP_PASS, 32'd5,        32'd3, 1'b1, 32'h00000005, 5'b10000};
      vecs[5]  = '{"not_5",      OP_NOT,  32'd5,        32'd3, 1'b1, 32'hFFFFFFFA, 5'b10100};
      vecs[6]  = '{"or_5_3",     OP_OR,   32'd5,        32'd3, 1'b1, 32'h00000007, 5'b10000};
      vecs[7]  = '{"and_5_3",    OP_AND,  32'd5,        32'd3, 1'b1, 32'h00000001, 5'b10000};
      vecs[8]  = '{"add_wrap",   OP_ADD,  32'hFFFFFFFF, 32'd1, 1'b1, 32'h00000000, 5'b11010};
      vecs[9]  = '{"dec_zero",   OP_DEC,  32'h00000000, 32'd7, 1'b1, 32'hFFFFFFFF, 5'b10110};
      vecs[10] = '{"add_ovf",    OP_ADD,  32'h7FFFFFFF, 32'd1, 1'b1, 32'h80000000, 5'b10101};
      vecs[11] = '{"sub_ovf",    OP_SUB,  32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 5'b10001};
      vecs[12] = '{"sub_borrow", OP_SUB,  32'd3,        32'd5, 1'b1, 32'hFFFFFFFE, 5'b10110};
      vecs[13] = '{"inc_ovf",    OP_INC,  32'h7FFFFFFF, 32'd0, 1'b1, 32'h80000000, 5'b10101};
      vecs[14] = '{"inc_wrap",   OP_INC,  32'hFFFFFFFF, 32'd0, 1'b1, 32'h00000000, 5'b11010};
      vecs[15] = '{"dec_ovf",    OP_DEC,  32'h80000000, 32'd0, 1'b1, 32'h7FFFFFFF, 5'b10001};
      vecs[16] = '{"and_zero",   OP_AND,  32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 32'h00000000, 5'b11000};
      vecs[17] = '{"disabled",   OP_ADD,  32'd5,        32'd3, 1'b0, 32'h00000000, 5'b00000};
      vecs[18] = '{"reenable",   OP_ADD,  32'd5,        32'd3, 1'b1, 32'h00000008, 5'b10000};
      vecs[19] = '{"sub_equal",  OP_SUB,  32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 5'b11000};

      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      A        = '0;
      B        = '0;
      opcode   = OP_ADD;
      enable   = 1'b0;

      // Reset state
      #2;
      check("reset_result", result, 32'h0);
      check("reset_flags", flags_now(), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors, one per cycle with a new opcode each time
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         A      = vecs[i].a;
         B      = vecs[i].b;
         opcode = vecs[i].op;
         enable = vecs[i].en;
         @(posedge clk);
         #1;
         check({vecs[i].name, "_result"}, result, vecs[i].exp_result);
         check({vecs[i].name, "_flags"}, flags_now(), {27'd0, vecs[i].exp_flags});
      end

      // Input change between edges must not disturb the registered output
      @(negedge clk);
      A = 32'd100; B = 32'd23; opcode = OP_ADD; enable = 1'b1;
      @(posedge clk);
      #1;
      check("hold_before", result, 32'd123);
      A = 32'd1; B = 32'd1; opcode = OP_SUB;
      #3;
      check("hold_between", result, 32'd123);
      @(posedge clk);
      #1;
      check("hold_after", result, 32'd0);
      check("hold_after_flags", flags_now(), 32'b11000);

      // Asynchronous reset mid-cycle clears outputs without a clock edge
      @(negedge clk);
      A = 32'd9; B = 32'd0; opcode = OP_PASS; enable = 1'b1;
      @(posedge clk);
      #1;
      check("pre_reset_result", result, 32'd9);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_result", result, 32'h0);
      check("async_reset_flags", flags_now(), 32'h0);
      // Held in reset across an enabled edge, outputs stay 0
      @(posedge clk);
      #1;
      check("held_reset_result", result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("released_result", result, 32'h0);
      check("released_flags", flags_now(), 32'h0);
      @(posedge clk);
      #1;
      check("post_reset_result", result, 32'd9);
      check("post_reset_flags", flags_now(), 32'b10000);

      // Enable toggling every cycle
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         A = 32'd20 + 32'(i); B = 32'd0; opcode = OP_INC; enable = (i % 2 == 0);
         @(posedge clk);
         #1;
         check("toggle_result", result, (i % 2 == 0) ? 32'd21 + 32'(i) : 32'd0);
         check("toggle_valid", {31'd0, valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
